// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing defaults, axis-total helper and the sync/blank bundle
// carried through the output delay line.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_timing_t;

    // Syncs idle high, video blanked
    localparam vga_timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster coordinate / VGA pin bundle between the timing generator and its consumers.
// VGA_FRAME_COUNT_EN adds the 16-bit frame counter.
interface vga_timing_gen_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        active;
    logic        frame_start;
    logic        line_start;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;

    modport master (output hcount, vcount, active, frame_start, line_start,
                           vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_count);
    modport slave  (input  hcount, vcount, active, frame_start, line_start,
                           vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_count);
`else
    modport master (output hcount, vcount, active, frame_start, line_start,
                           vga_hs, vga_vs, vga_blank_n, vga_sync_n);
    modport slave  (input  hcount, vcount, active, frame_start, line_start,
                           vga_hs, vga_vs, vga_blank_n, vga_sync_n);
`endif
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// DEPTH-stage shift register for hs/vs/blank_n; every stage resets to the idle value.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  vga_timing_t i_d,
    output vga_timing_t o_q
);

    if (DEPTH == 0) begin : g_thru
        assign o_q = i_d;
    end else begin : g_pipe
        vga_timing_t r_stage [DEPTH];

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= TIMING_IDLE;
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates plus delayed sync/blank pins.
// Define VGA_FRAME_COUNT_EN to add the frame_count output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 0..4");
    end

    // 11-bit compares so a sync region ending exactly at 1024 still decodes
    localparam logic [9:0]  L_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  L_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] L_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] L_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] L_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] L_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] L_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_active;
    logic        r_frame_start;
    logic        r_line_start;
    logic [9:0]  w_hnext;
    logic [9:0]  w_vnext;
    logic        w_hwrap;
    logic        w_vwrap;
    vga_timing_t w_raw;
    vga_timing_t w_pin;

    always_comb begin
        w_hwrap = (r_hcount == L_H_LAST);
        w_vwrap = (r_vcount == L_V_LAST);
        w_hnext = w_hwrap ? 10'd0 : r_hcount + 10'd1;
        w_vnext = r_vcount;
        if (w_hwrap) begin
            w_vnext = w_vwrap ? 10'd0 : r_vcount + 10'd1;
        end
    end

    // Flags come from next-state counts so they line up with hcount/vcount
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_hcount      <= w_hnext;
            r_vcount      <= w_vnext;
            r_active      <= ({1'b0, w_hnext} < L_H_ACT) && ({1'b0, w_vnext} < L_V_ACT);
            r_line_start  <= (w_hnext == 10'd0);
            r_frame_start <= (w_hnext == 10'd0) && (w_vnext == 10'd0);
        end
    end

    always_comb begin
        w_raw.hs      = !(({1'b0, r_hcount} >= L_HS_BEG) && ({1'b0, r_hcount} < L_HS_END));
        w_raw.vs      = !(({1'b0, r_vcount} >= L_VS_BEG) && ({1'b0, r_vcount} < L_VS_END));
        w_raw.blank_n = r_active;
    end

    vga_delay_line #(.DEPTH(PIPE_DELAY)) u_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .i_d     (w_raw),
        .o_q     (w_pin)
    );

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_hwrap && w_vwrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign vga.frame_count = r_frame_count;
`endif

    assign vga.hcount      = r_hcount;
    assign vga.vcount      = r_vcount;
    assign vga.active      = r_active;
    assign vga.frame_start = r_frame_start;
    assign vga.line_start  = r_line_start;
    assign vga.vga_hs      = w_pin.hs;
    assign vga.vga_vs      = w_pin.vs;
    assign vga.vga_blank_n = w_pin.blank_n;
    assign vga.vga_sync_n  = 1'b0;

endmodule
